dvga_pixel_gen: RTL and testbench

Display timing and pixel-fetch stage that sits directly upstream of the sprite overlay.
- Runs the horizontal and vertical counters and generates hsync, vsync and blank.
- Reads one RGB565 scanline from the line buffer and expands it to 8:8:8.
- Presents xpos/ypos, r/g/b, hsync, vsync and blank mutually aligned, ready for the sprite stage's xpos_i/ypos_i/r_i/g_i/b_i/hsync_i/vsync_i/blank_i.
- Issues per-line and per-frame requests to the line-buffer DMA.

---
 rtl/dvga_pixel_gen.sv | 147 ++++++++++++++
 tb/tb_dvga_pixel_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvga_pixel_gen.sv
// Display timing generator and line-buffer pixel fetch with a fixed two-clock output pipeline.
// Sync/blank, position and RGB888 leave together, aligned for the sprite overlay stage.
module dvga_pixel_gen #(
   parameter int unsigned H_VIS    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_TOT    = 800,
   parameter int unsigned V_VIS    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_TOT    = 525,
   parameter bit          SYNC_POL = 1'b0,
   localparam int unsigned XCNTW   = $clog2(H_TOT),
   localparam int unsigned YCNTW   = $clog2(V_TOT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   output logic [9:0]       linebuf_adr_o,
   input  logic [15:0]      linebuf_dat_i,
   output logic             line_req_o,
   output logic [YCNTW-1:0] line_y_o,
   output logic             frame_start_o,
   output logic [XCNTW-1:0] xpos_o,
   output logic [YCNTW-1:0] ypos_o,
   output logic [7:0]       r_o,
   output logic [7:0]       g_o,
   output logic [7:0]       b_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             blank_o
);

   localparam logic [XCNTW-1:0] HLast = XCNTW'(H_TOT - 1);
   localparam logic [XCNTW-1:0] HReq  = XCNTW'(H_VIS - 1);
   localparam logic [YCNTW-1:0] VLast = YCNTW'(V_TOT - 1);
   localparam int unsigned HsBeg = H_VIS + H_FP;
   localparam int unsigned HsEnd = H_VIS + H_FP + H_SYNC;
   localparam int unsigned VsBeg = V_VIS + V_FP;
   localparam int unsigned VsEnd = V_VIS + V_FP + V_SYNC;

   logic [XCNTW-1:0] hcnt_q, hcnt_d;
   logic [YCNTW-1:0] vcnt_q, vcnt_d;
   logic             h_wrap;
   logic [31:0]      hx, vy, vy_d;

   assign hx   = 32'(hcnt_q);
   assign vy   = 32'(vcnt_q);
   assign vy_d = 32'(vcnt_d);

   // ---------------------------------------------------------------- counters
   always_comb begin
      h_wrap = (hcnt_q == HLast);
      hcnt_d = '0;
      vcnt_d = '0;
      if (en_i) begin
         hcnt_d = h_wrap ? '0 : hcnt_q + XCNTW'(1);
         vcnt_d = vcnt_q;
         if (h_wrap) begin
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + YCNTW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // ---------------------------------------------------------------- stage 0 decode
   logic blank0, hs0, vs0;

   always_comb begin
      blank0 = !en_i || (hx >= H_VIS) || (vy >= V_VIS);
      hs0    = (en_i && (hx >= HsBeg) && (hx < HsEnd)) ? SYNC_POL : ~SYNC_POL;
      vs0    = (en_i && (vy >= VsBeg) && (vy < VsEnd)) ? SYNC_POL : ~SYNC_POL;
      linebuf_adr_o = blank0 ? '0 : 10'(hcnt_q);
   end

   // ---------------------------------------------------------------- DMA requests
   logic             req_line_ok, load_y;
   logic [YCNTW-1:0] y_target;
   logic [YCNTW-1:0] line_y_q;

   always_comb begin
      req_line_ok   = ((vy + 32'd1) < V_VIS) || (vcnt_q == VLast);
      line_req_o    = !rst && en_i && (hcnt_q == HReq) && req_line_ok;
      frame_start_o = !rst && en_i && (hcnt_q == '0) && (vcnt_q == '0);
      // Line number is loaded on entry to the request column so it is valid during the pulse.
      load_y   = (hcnt_d == HReq) && (((vy_d + 32'd1) < V_VIS) || (vcnt_d == VLast));
      y_target = (vcnt_d == VLast) ? '0 : vcnt_d + YCNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_y_q <= '0;
      end else if (load_y) begin
         line_y_q <= y_target;
      end
   end

   assign line_y_o = line_y_q;

   // ---------------------------------------------------------------- stages 1 and 2
   logic [XCNTW-1:0] x1_q;
   logic [YCNTW-1:0] y1_q;
   logic             hs1_q, vs1_q, blank1_q;

   // Stage 1 resets to blank/inactive so no visible pixel escapes in the clocks after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q     <= '0;
         y1_q     <= '0;
         hs1_q    <= ~SYNC_POL;
         vs1_q    <= ~SYNC_POL;
         blank1_q <= 1'b1;
         xpos_o   <= '0;
         ypos_o   <= '0;
         r_o      <= '0;
         g_o      <= '0;
         b_o      <= '0;
         hsync_o  <= ~SYNC_POL;
         vsync_o  <= ~SYNC_POL;
         blank_o  <= 1'b1;
      end else begin
         x1_q     <= hcnt_q;
         y1_q     <= vcnt_q;
         hs1_q    <= hs0;
         vs1_q    <= vs0;
         blank1_q <= blank0;
         xpos_o   <= x1_q;
         ypos_o   <= y1_q;
         hsync_o  <= hs1_q;
         vsync_o  <= vs1_q;
         blank_o  <= blank1_q;
         r_o      <= blank1_q ? '0 : {linebuf_dat_i[15:11], linebuf_dat_i[15:13]};
         g_o      <= blank1_q ? '0 : {linebuf_dat_i[10:5], linebuf_dat_i[10:9]};
         b_o      <= blank1_q ? '0 : {linebuf_dat_i[4:0], linebuf_dat_i[4:2]};
      end
   end

endmodule

// File: tb/tb_dvga_pixel_gen.sv
// Scoreboard bench for dvga_pixel_gen: randomized enable/reset traffic against a frame-time model.
// Vertical geometry is shrunk so whole frames fit in a short run; horizontal timing is default.
module tb_dvga_pixel_gen;

   localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_TOT = 800;
   localparam int V_VIS = 8, V_FP = 1, V_SYNC = 2, V_TOT = 13;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int XW = $clog2(H_TOT);
   localparam int YW = $clog2(V_TOT);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_i = 1'b1;
   logic [9:0]    linebuf_adr_o;
   logic [15:0]   linebuf_dat_i = '0;
   logic          line_req_o, frame_start_o;
   logic [YW-1:0] line_y_o, ypos_o;
   logic [XW-1:0] xpos_o;
   logic [7:0]    r_o, g_o, b_o;
   logic          hsync_o, vsync_o, blank_o;

   dvga_pixel_gen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOT(H_TOT),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOT(V_TOT)
   ) dut (
      .clk(clk), .rst(rst), .en_i(en_i),
      .linebuf_adr_o(linebuf_adr_o), .linebuf_dat_i(linebuf_dat_i),
      .line_req_o(line_req_o), .line_y_o(line_y_o), .frame_start_o(frame_start_o),
      .xpos_o(xpos_o), .ypos_o(ypos_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:1023];
   always @(posedge clk) linebuf_dat_i <= mem[linebuf_adr_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   typedef struct {
      int cyc; bit chk; bit rst;
      logic [XW-1:0] x; logic [YW-1:0] y;
      logic blank, hs, vs; logic [7:0] r, g, b;
   } out_t;
   typedef struct {
      int cyc; bit chk;
      logic [9:0] adr; logic fs, lr; logic [YW-1:0] ly;
   } cmb_t;

   out_t oq[$];
   cmb_t cq[$];

   int t = 0;      // counter state as elapsed enabled clocks since (0,0)
   bit armed = 0;

   function automatic logic [7:0] widen(int v, int bits);
      return 8'((v << (8 - bits)) | (v >> (2 * bits - 8)));
   endfunction

   // One clock of stimulus; the expected response for this counter state is queued.
   task automatic step(bit r_v, bit e_v);
      out_t o;
      cmb_t c;
      int h, v, d;
      bit vis;
      @(posedge clk);
      #1;
      rst  = r_v;
      en_i = e_v;
      h    = t % H_TOT;
      v    = t / H_TOT;
      vis  = e_v && (h < H_VIS) && (v < V_VIS);
      d    = vis ? int'(mem[h]) : 0;
      o.cyc = cyc; o.chk = armed; o.rst = r_v;
      o.x = XW'(h); o.y = YW'(v);
      o.blank = !vis;
      o.hs = (e_v && h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? 1'b0 : 1'b1;
      o.vs = (e_v && v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? 1'b0 : 1'b1;
      o.r = vis ? widen((d / 2048) % 32, 5) : 8'h0;
      o.g = vis ? widen((d / 32) % 64, 6) : 8'h0;
      o.b = vis ? widen(d % 32, 5) : 8'h0;
      c.cyc = cyc; c.chk = armed;
      c.adr = vis ? 10'(h) : 10'h0;
      c.fs  = e_v && !r_v && (t == 0);
      c.lr  = e_v && !r_v && (h == H_VIS - 1) && ((v + 1 < V_VIS) || (v == V_TOT - 1));
      c.ly  = (v == V_TOT - 1) ? '0 : YW'(v + 1);
      oq.push_back(o);
      cq.push_back(c);
      armed = 1;
      t = (r_v || !e_v) ? 0 : (t + 1) % FRAME;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   // Monitor: combinational outputs for this cycle, pipelined outputs from two cycles back.
   always @(negedge clk) begin
      cmb_t c;
      out_t o;
      bit   rz;
      while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
         c = cq.pop_front();
         if (c.chk) begin
            chk("linebuf_adr", 64'(linebuf_adr_o), 64'(c.adr));
            chk("frame_start", 64'(frame_start_o), 64'(c.fs));
            chk("line_req", 64'(line_req_o), 64'(c.lr));
            if (c.lr) chk("line_y", 64'(line_y_o), 64'(c.ly));
         end
      end
      while (oq.size() > 0 && oq[0].cyc < cyc - 2) void'(oq.pop_front());
      if (oq.size() >= 2 && oq[0].cyc == cyc - 2) begin
         o = oq.pop_front();
         if (o.chk) begin
            rz = o.rst || oq[0].rst;
            if (rz) begin
               o.x = '0; o.y = '0; o.blank = 1'b1; o.hs = 1'b1; o.vs = 1'b1;
               o.r = '0; o.g = '0; o.b = '0;
            end
            chk("pos", 64'({xpos_o, ypos_o}), 64'({o.x, o.y}));
            chk("pix", 64'({blank_o, hsync_o, vsync_o, r_o, g_o, b_o}),
                64'({o.blank, o.hs, o.vs, o.r, o.g, o.b}));
         end
      end
   end

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic run_to(int tt);
      int guard = 0;
      while (t != tt && guard < FRAME + 2) begin
         step(0, 1);
         guard++;
      end
      chk("reach_state", 64'(t), 64'(tt));
   endtask

   initial begin
      int p1 = -1, p2 = -1, lr_n = 0, vs_n = 0, hs_run = 0;
      int hs_w = -1, hs_x = -1, vs_y = -1, vs_x = -1, bl_x = -1;
      logic prev_hs = 1'b1, prev_vs = 1'b1, prev_bl = 1'b1;

      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[0] = 16'hF800;
      mem[1] = 16'h07E0;

      // Reset values
      repeat (3) step(1, 1);
      probe();
      chk("rst_blank", 64'(blank_o), 64'd1);
      chk("rst_hsync", 64'(hsync_o), 64'd1);
      chk("rst_vsync", 64'(vsync_o), 64'd1);
      chk("rst_rgb", 64'({r_o, g_o, b_o}), 64'd0);
      chk("rst_line_req", 64'(line_req_o), 64'd0);
      chk("rst_line_y", 64'(line_y_o), 64'd0);
      chk("rst_frame_start", 64'(frame_start_o), 64'd0);

      // Pixel latency
      step(0, 1); probe();
      chk("lat_frame_start", 64'(frame_start_o), 64'd1);
      step(0, 1);
      step(0, 1); probe();
      chk("lat_px0_rgb", 64'({r_o, g_o, b_o}), 64'hFF0000);
      chk("lat_px0_x", 64'(xpos_o), 64'd0);
      chk("lat_px0_blank", 64'(blank_o), 64'd0);
      step(0, 1); probe();
      chk("lat_px1_rgb", 64'({r_o, g_o, b_o}), 64'h00FF00);
      chk("lat_px1_x", 64'(xpos_o), 64'd1);

      // Steady timing over two frame boundaries
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         step(0, 1); probe();
         if (frame_start_o) begin
            if (p1 < 0) p1 = cyc;
            else if (p2 < 0) p2 = cyc;
         end
         if (p1 >= 0 && p2 < 0) begin
            if (line_req_o) lr_n++;
            if (!vsync_o) vs_n++;
         end
         if (!hsync_o) begin
            if (prev_hs) begin
               hs_run = 0;
               if (hs_x < 0) hs_x = int'(xpos_o);
            end
            hs_run++;
         end else if (!prev_hs && hs_w < 0) begin
            hs_w = hs_run;
         end
         if (!vsync_o && prev_vs && vs_y < 0) begin
            vs_y = int'(ypos_o);
            vs_x = int'(xpos_o);
         end
         if (blank_o && !prev_bl && bl_x < 0) bl_x = int'(xpos_o);
         prev_hs = hsync_o; prev_vs = vsync_o; prev_bl = blank_o;
      end
      chk("frame_period", 64'(p2 - p1), 64'(FRAME));
      chk("line_reqs_per_frame", 64'(lr_n), 64'(V_VIS));
      chk("vsync_low_clocks", 64'(vs_n), 64'(V_SYNC * H_TOT));
      chk("vsync_start_y", 64'(vs_y), 64'(V_VIS + V_FP));
      chk("vsync_start_x", 64'(vs_x), 64'd0);
      chk("hsync_width", 64'(hs_w), 64'(H_SYNC));
      chk("hsync_start_x", 64'(hs_x), 64'(H_VIS + H_FP));
      chk("blank_rise_x", 64'(bl_x), 64'(H_VIS));

      // Enable dropped mid-frame, then restored
      run_to(5 * H_TOT + 300);
      step(0, 0); probe(); chk("en_drop_no_req0", 64'(line_req_o), 64'd0);
      step(0, 0); probe(); chk("en_drop_no_req1", 64'(line_req_o), 64'd0);
      step(0, 0); probe(); chk("en_drop_blank", 64'(blank_o), 64'd1);
      repeat (3) step(0, 0);
      step(0, 1); probe();
      chk("en_rise_frame_start", 64'(frame_start_o), 64'd1);
      chk("en_rise_adr", 64'(linebuf_adr_o), 64'd0);
      step(0, 1);
      step(0, 1); probe();
      chk("en_restart_pos", 64'({xpos_o, ypos_o}), 64'd0);
      chk("en_restart_blank", 64'(blank_o), 64'd0);

      // Same with reset
      run_to(5 * H_TOT + 300);
      step(1, 1); probe(); chk("rst_drop_no_req", 64'(line_req_o), 64'd0);
      step(1, 1); probe(); chk("rst_drop_blank", 64'(blank_o), 64'd1);
      step(1, 1);
      step(0, 1); probe();
      chk("rst_rise_frame_start", 64'(frame_start_o), 64'd1);
      step(0, 1);
      step(0, 1); probe();
      chk("rst_restart_pos", 64'({xpos_o, ypos_o}), 64'd0);
      chk("rst_restart_blank", 64'(blank_o), 64'd0);

      // Randomized enable/reset disturbances
      for (int k = 0; k < 16; k++) begin
         int n, kind, len;
         n    = int'($urandom_range(50, 2500));
         kind = int'($urandom_range(0, 2));
         len  = int'($urandom_range(1, 6));
         repeat (n) step(0, 1);
         for (int j = 0; j < len; j++) begin
            case (kind)
               0:       step(0, 0);
               1:       step(1, 1'($urandom));
               default: step(1'($urandom), 1'($urandom));
            endcase
         end
      end
      repeat (4) step(0, 1);
      probe();
      probe();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
